uart_tx_arbiter: RTL

//  Shares one uart_tx transmitter between NUM_SRC byte-stream requesters. Arbitration is round-robin and frame-locked.
//  A granted source keeps the line until it sends its Last byte, hits MAX_FRAME_BYTES, or times out.

---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, header tag
// and the header byte builder.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HDR       = 3'd1,
        S_DATA      = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_ACT  = 3'd4,
        S_WAIT_DONE = 3'd5
    } arb_state_e;

    localparam logic [3:0] HDR_TAG = 4'hA;

    // Header byte announcing which source owns the frame that follows.
    function automatic logic [7:0] hdr_byte(input logic [3:0] src);
        return {HDR_TAG, src};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester strictly after the
// pointer (wrapping) wins. Produces a one-hot grant, its index and a flag.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] k;

    // Scan sources ptr+1 .. ptr+N and keep the first one that requests.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = '0;
        for (int i = 1; i <= N; i++) begin
            k = IW'((int'(ptr_i) + i) % N);
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_SRC byte-stream sources. A granted source
// owns the line until its Last byte, MAX_FRAME_BYTES data bytes, or
// IDLE_TIMEOUT clocks without a byte. Optional source-ID header per frame.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int SRC_ID_HEADER   = 1,
    parameter int MAX_FRAME_BYTES = 64,
    parameter int IDLE_TIMEOUT    = 1024
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset_n,
    input  logic [NUM_SRC-1:0]     i_Req_Valid,
    input  logic [8*NUM_SRC-1:0]   i_Req_Data,
    input  logic [NUM_SRC-1:0]     i_Req_Last,
    output logic [NUM_SRC-1:0]     o_Req_Ready,
    output logic [NUM_SRC-1:0]     o_Grant,
    output logic                   o_Tx_DV,
    output logic [7:0]             o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done,
    output logic                   o_Busy,
    output logic                   o_Timeout,
    output logic                   o_Trunc
);

    localparam int IW  = $clog2(NUM_SRC);
    localparam int BCW = $clog2(MAX_FRAME_BYTES + 1);
    localparam int TCW = $clog2(IDLE_TIMEOUT);
    localparam logic [BCW-1:0] MAX_B    = BCW'(MAX_FRAME_BYTES);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(IDLE_TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [BCW-1:0]     bcnt_q, bcnt_d;
    logic [TCW-1:0]     tcnt_q, tcnt_d;
    logic               last_q, last_d;
    logic               hdr_q, hdr_d;
    logic [7:0]         byte_q, byte_d;
    logic               tmo_q, tmo_d;
    logic               trunc_q, trunc_d;

    logic [NUM_SRC-1:0] rr_gnt;
    logic [IW-1:0]      rr_idx;
    logic               rr_any;
    logic               tx_idle;
    logic               own_valid;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .req_i (i_Req_Valid),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    // uart_tx is idle only once its two-cycle Done pulse has also cleared.
    assign tx_idle   = !i_Tx_Active && !i_Tx_Done;
    assign own_valid = i_Req_Valid[gidx_q];

    assign o_Grant     = grant_q;
    assign o_Req_Ready = (state_q == S_DATA) ? grant_q : '0;
    assign o_Tx_Byte   = byte_q;
    assign o_Busy      = (state_q != S_IDLE);
    assign o_Timeout   = tmo_q;
    assign o_Trunc     = trunc_q;

    // Next-state logic: arbitration, byte capture, Tx handshake and release.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        last_d  = last_q;
        hdr_d   = hdr_q;
        byte_d  = byte_q;
        tmo_d   = 1'b0;
        trunc_d = 1'b0;
        o_Tx_DV = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rr_any) begin
                    grant_d = rr_gnt;
                    gidx_d  = rr_idx;
                    bcnt_d  = '0;
                    tcnt_d  = '0;
                    last_d  = 1'b0;
                    hdr_d   = 1'b0;
                    state_d = (SRC_ID_HEADER != 0) ? S_HDR : S_DATA;
                end
            end
            S_HDR: begin
                byte_d  = hdr_byte(4'(gidx_q));
                hdr_d   = 1'b1;
                state_d = S_ISSUE;
            end
            S_DATA: begin
                if (own_valid) begin
                    byte_d  = i_Req_Data[{gidx_q, 3'b000} +: 8];
                    last_d  = i_Req_Last[gidx_q];
                    bcnt_d  = bcnt_q + BCW'(1);
                    state_d = S_ISSUE;
                end else if (tcnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    ptr_d   = gidx_q;
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end
            S_ISSUE: begin
                if (tx_idle) begin
                    o_Tx_DV = 1'b1;
                    state_d = S_WAIT_ACT;
                end
            end
            S_WAIT_ACT: begin
                if (i_Tx_Active) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        tcnt_d  = '0;
                        state_d = S_DATA;
                    end else if (last_q) begin
                        ptr_d   = gidx_q;
                        grant_d = '0;
                        state_d = S_IDLE;
                    end else if (bcnt_q == MAX_B) begin
                        trunc_d = 1'b1;
                        ptr_d   = gidx_q;
                        grant_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        tcnt_d  = '0;
                        state_d = S_DATA;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and datapath registers; pointer starts at NUM_SRC-1 so source 0 wins first.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= IW'(NUM_SRC - 1);
            bcnt_q  <= '0;
            tcnt_q  <= '0;
            last_q  <= 1'b0;
            hdr_q   <= 1'b0;
            byte_q  <= '0;
            tmo_q   <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
            last_q  <= last_d;
            hdr_q   <= hdr_d;
            byte_q  <= byte_d;
            tmo_q   <= tmo_d;
            trunc_q <= trunc_d;
        end
    end

endmodule
